// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and the jump-decode flag bundle.
package mips_pkg;

    localparam int unsigned OP_W           = 6;
    localparam int unsigned REG_IDX_W      = 5;
    localparam int unsigned RA_REG_DEFAULT = 31;

    localparam logic [OP_W-1:0] OP_SPECIAL = 6'b000000;
    localparam logic [OP_W-1:0] OP_J       = 6'b000010;
    localparam logic [OP_W-1:0] OP_JAL     = 6'b000011;
    localparam logic [OP_W-1:0] FUNCT_JR   = 6'b001000;
    localparam logic [OP_W-1:0] FUNCT_JALR = 6'b001001;

    // Control flags produced by the jump decoder
    typedef struct packed {
        logic jump;
        logic ret;
        logic rd_sel;
        logic use_reg;
        logic push;
        logic pop;
    } jmp_dec_t;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: overwrite-on-full push, ignored pop-on-empty,
// pop+push replaces the top entry.
module ras_stack #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_push_data,
    output logic [WIDTH-1:0] o_top_c,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] sp_q, sp_d;
    logic [PTR_W-1:0] top_idx_c, wr_idx_c;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             wr_en_c;
    logic             do_pop_c;

    // sp points at the next free slot; when full that slot is the oldest entry
    always_comb begin
        top_idx_c = sp_q - PTR_W'(1);
        do_pop_c  = i_pop && (cnt_q != '0);
        sp_d      = sp_q;
        cnt_d     = cnt_q;
        wr_en_c   = 1'b0;
        wr_idx_c  = sp_q;
        if (do_pop_c && i_push) begin
            wr_en_c  = 1'b1;
            wr_idx_c = top_idx_c;
        end else if (do_pop_c) begin
            sp_d  = top_idx_c;
            cnt_d = cnt_q - CNT_W'(1);
        end else if (i_push) begin
            wr_en_c = 1'b1;
            sp_d    = sp_q + PTR_W'(1);
            if (cnt_q != CNT_W'(DEPTH)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        full_d  = (cnt_d == CNT_W'(DEPTH));
        empty_d = (cnt_d == '0);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sp_q    <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            sp_q    <= sp_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    // Entries need no reset: an empty stack never exposes them
    always_ff @(posedge i_clk) begin
        if (wr_en_c) begin
            mem_q[wr_idx_c] <= i_push_data;
        end
    end

    assign o_top_c = mem_q[top_idx_c];
    assign o_full  = full_q;
    assign o_empty = empty_q;

endmodule

// File: rtl/u_jump_ras.sv
// ID-stage jump resolution (J/JAL/JR/JALR) with registered outputs and a
// return-address stack predicting JR $31 targets.
module u_jump_ras
    import mips_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned SIZEOP     = 6,
    parameter int unsigned RAS_DEPTH  = 8,
    parameter int unsigned RA_REG     = RA_REG_DEFAULT,
    parameter int unsigned ABS_TARGET = 0
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_valid,
    input  logic                  i_stall,
    input  logic                  i_flush,
    input  logic [DATA_WIDTH-1:0] i_currentpc,
    input  logic [DATA_WIDTH-1:0] i_instruccion,
    input  logic [DATA_WIDTH-1:0] i_regA,
    output logic                  o_valid,
    output logic                  o_jump,
    output logic [DATA_WIDTH-1:0] o_pcjump,
    output logic [DATA_WIDTH-1:0] o_return_address,
    output logic                  o_rd_selector,
    output logic                  o_return,
    output logic [DATA_WIDTH-1:0] o_ras_pred,
    output logic                  o_ras_hit,
    output logic                  o_ras_full,
    output logic                  o_ras_empty
);

    logic [SIZEOP-1:0]     op_c, funct_c;
    logic [REG_IDX_W-1:0]  rs_c, rd_c;
    logic [DATA_WIDTH-1:0] ret_addr_c, rel_target_c, abs_target_c, target_c;
    logic [DATA_WIDTH-1:0] ras_top_c;
    logic                  ras_empty_c;
    logic                  accept_c, push_c, pop_c, pop_live_c;
    logic                  unused_c;
    jmp_dec_t              dec_c;

    logic                  valid_q, valid_d;
    logic                  jump_q, jump_d;
    logic [DATA_WIDTH-1:0] pcjump_q, pcjump_d;
    logic [DATA_WIDTH-1:0] ret_addr_q, ret_addr_d;
    logic                  rd_sel_q, rd_sel_d;
    logic                  ret_q, ret_d;
    logic [DATA_WIDTH-1:0] pred_q, pred_d;
    logic                  hit_q, hit_d;

    assign unused_c = ^{i_instruccion[20:16], i_instruccion[10:6]};

    // Instruction decode and target arithmetic (all modulo 2^DATA_WIDTH)
    always_comb begin
        op_c         = i_instruccion[DATA_WIDTH-1 -: SIZEOP];
        funct_c      = i_instruccion[SIZEOP-1:0];
        rs_c         = i_instruccion[25:21];
        rd_c         = i_instruccion[15:11];
        ret_addr_c   = i_currentpc + DATA_WIDTH'(1);
        rel_target_c = i_currentpc + DATA_WIDTH'(i_instruccion[25:0]);
        abs_target_c = {i_currentpc[DATA_WIDTH-1:26], i_instruccion[25:0]};
        dec_c        = '0;
        if (op_c == SIZEOP'(OP_J)) begin
            dec_c.jump = 1'b1;
        end else if (op_c == SIZEOP'(OP_JAL)) begin
            dec_c.jump   = 1'b1;
            dec_c.ret    = 1'b1;
            dec_c.rd_sel = 1'b1;
            dec_c.push   = 1'b1;
        end else if (op_c == SIZEOP'(OP_SPECIAL) && funct_c == SIZEOP'(FUNCT_JR)) begin
            dec_c.jump    = 1'b1;
            dec_c.use_reg = 1'b1;
            dec_c.pop     = (rs_c == REG_IDX_W'(RA_REG));
        end else if (op_c == SIZEOP'(OP_SPECIAL) && funct_c == SIZEOP'(FUNCT_JALR)) begin
            dec_c.jump    = 1'b1;
            dec_c.ret     = 1'b1;
            dec_c.use_reg = 1'b1;
            dec_c.pop     = (rs_c == REG_IDX_W'(RA_REG));
            dec_c.push    = (rd_c == REG_IDX_W'(RA_REG));
        end
        if (dec_c.use_reg) begin
            target_c = i_regA;
        end else if (ABS_TARGET != 0) begin
            target_c = abs_target_c;
        end else begin
            target_c = rel_target_c;
        end
    end

    assign accept_c   = i_valid && !i_stall && !i_flush;
    assign push_c     = accept_c && dec_c.push;
    assign pop_c      = accept_c && dec_c.pop;
    assign pop_live_c = dec_c.pop && !ras_empty_c;

    ras_stack #(
        .DEPTH (RAS_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_ras_stack (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_push      (push_c),
        .i_pop       (pop_c),
        .i_push_data (ret_addr_c),
        .o_top_c     (ras_top_c),
        .o_full      (o_ras_full),
        .o_empty     (ras_empty_c)
    );

    // Output register next-state: flush beats stall, stall holds everything
    always_comb begin
        valid_d    = valid_q;
        jump_d     = jump_q;
        pcjump_d   = pcjump_q;
        ret_addr_d = ret_addr_q;
        rd_sel_d   = rd_sel_q;
        ret_d      = ret_q;
        pred_d     = pred_q;
        hit_d      = hit_q;
        if (i_flush || !i_stall) begin
            valid_d    = accept_c;
            pcjump_d   = target_c;
            ret_addr_d = ret_addr_c;
            jump_d     = accept_c && dec_c.jump;
            rd_sel_d   = accept_c && dec_c.rd_sel;
            ret_d      = accept_c && dec_c.ret;
            pred_d     = (accept_c && pop_live_c) ? ras_top_c : '0;
            hit_d      = accept_c && pop_live_c && (ras_top_c == target_c);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            valid_q    <= 1'b0;
            jump_q     <= 1'b0;
            pcjump_q   <= '0;
            ret_addr_q <= '0;
            rd_sel_q   <= 1'b0;
            ret_q      <= 1'b0;
            pred_q     <= '0;
            hit_q      <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            jump_q     <= jump_d;
            pcjump_q   <= pcjump_d;
            ret_addr_q <= ret_addr_d;
            rd_sel_q   <= rd_sel_d;
            ret_q      <= ret_d;
            pred_q     <= pred_d;
            hit_q      <= hit_d;
        end
    end

    assign o_valid          = valid_q;
    assign o_jump           = jump_q;
    assign o_pcjump         = pcjump_q;
    assign o_return_address = ret_addr_q;
    assign o_rd_selector    = rd_sel_q;
    assign o_return         = ret_q;
    assign o_ras_pred       = pred_q;
    assign o_ras_hit        = hit_q;
    assign o_ras_empty      = ras_empty_c;

endmodule
